pipe_core_p: RTL and testbench

PIPE_CORE_P -- requirements
Module: pipe_core_p

---
 rtl/pipe_core_p.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_pipe_core_p.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_core_p.sv
// rtl/pipe_core_p.sv - five-stage in-order pipelined core with load/store, branch and halt
//
// Purpose: F/D/E/M/W pipeline executing 16-bit instructions laid out as
//          [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4 (imm4 sign-extended).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       global advance; low freezes all state
//   imem_addr    fetch address (current PC)
//   imem_data    instruction at imem_addr, same cycle
//   result_w     writeback data
//   result_valid result_w is written to the register file this cycle
//   halted       HALT has reached writeback (sticky)
// Configuration:
//   PIPE_CORE_FWD_EN  defined: M-then-W operand forwarding into E, load-use stall only
//                     undefined: no forwarding, D stalls while E/M writes a D source
module pipe_core_p #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 12,
    parameter int DMEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [DATA_W-1:0] result_w,
    output logic              result_valid,
    output logic              halted
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_HALT = 4'd9
    } op_e;

    function automatic logic writes_rd(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD};
    endfunction

    function automatic logic uses_rs1(input op_e op);
        return (op != OP_NOP) && (op != OP_HALT);
    endfunction

    // Second operand is rs2 for register-register ops, rd for ST data and BEQ compare.
    function automatic logic uses_b(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ};
    endfunction

    // Pipeline state
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       fd_instr_q, fd_instr_d;
    logic [PC_W-1:0]   fd_pc_q, fd_pc_d;
    op_e               de_op_q, de_op_d;
    logic [3:0]        de_rd_q, de_rd_d;
    logic [3:0]        de_imm_q, de_imm_d;
    logic [DATA_W-1:0] de_a_q, de_a_d;
    logic [DATA_W-1:0] de_b_q, de_b_d;
    logic [PC_W-1:0]   de_pc_q, de_pc_d;
`ifdef PIPE_CORE_FWD_EN
    logic [3:0]        de_a_idx_q, de_a_idx_d;
    logic [3:0]        de_b_idx_q, de_b_idx_d;
`endif
    op_e               em_op_q, em_op_d;
    logic [3:0]        em_rd_q, em_rd_d;
    logic [DATA_W-1:0] em_alu_q, em_alu_d;
    logic [DATA_W-1:0] em_st_q, em_st_d;
    logic              mw_we_q, mw_we_d;
    logic [3:0]        mw_rd_q, mw_rd_d;
    logic [DATA_W-1:0] mw_res_q, mw_res_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];
    logic [DATA_W-1:0] dmem [2**DMEM_AW];

    logic              advance;
    op_e               d_op;
    logic [3:0]        d_rd, d_rs1, d_b_idx;
    logic [DATA_W-1:0] d_a, d_b;
    logic              de_we, em_we;
    logic              hit_e, stall;
    logic [DATA_W-1:0] m_res, e_a, e_b, e_imm, e_alu;
    logic              taken;
    logic [PC_W-1:0]   br_target;
    logic              halt_in_flight;

    assign advance      = enable && !halted_q;
    assign imem_addr    = pc_q;
    assign result_w     = mw_res_q;
    assign result_valid = mw_we_q;
    assign halted       = halted_q;

    assign de_we = writes_rd(de_op_q);
    assign em_we = writes_rd(em_op_q);

    // Decode; opcodes 10..15 collapse to NOP. Register reads bypass the W-stage write.
    always_comb begin
        d_op    = (fd_instr_q[15:12] > 4'd9) ? OP_NOP : op_e'(fd_instr_q[15:12]);
        d_rd    = fd_instr_q[11:8];
        d_rs1   = fd_instr_q[7:4];
        d_b_idx = (d_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) ? fd_instr_q[3:0] : d_rd;
        d_a     = (mw_we_q && mw_rd_q == d_rs1)   ? mw_res_q : rf_q[d_rs1];
        d_b     = (mw_we_q && mw_rd_q == d_b_idx) ? mw_res_q : rf_q[d_b_idx];
    end

    assign hit_e = de_we && ((uses_rs1(d_op) && de_rd_q == d_rs1) ||
                             (uses_b(d_op)   && de_rd_q == d_b_idx));

`ifdef PIPE_CORE_FWD_EN
    assign stall = hit_e && (de_op_q == OP_LD);
`else
    logic hit_m;
    assign hit_m = em_we && ((uses_rs1(d_op) && em_rd_q == d_rs1) ||
                             (uses_b(d_op)   && em_rd_q == d_b_idx));
    assign stall = hit_e || hit_m;
`endif

    // Memory stage result; load data is available combinationally in M.
    assign m_res = (em_op_q == OP_LD) ? dmem[em_alu_q[DMEM_AW-1:0]] : em_alu_q;

`ifdef PIPE_CORE_FWD_EN
    always_comb begin
        e_a = de_a_q;
        e_b = de_b_q;
        if (em_we && em_rd_q == de_a_idx_q)        e_a = m_res;
        else if (mw_we_q && mw_rd_q == de_a_idx_q) e_a = mw_res_q;
        if (em_we && em_rd_q == de_b_idx_q)        e_b = m_res;
        else if (mw_we_q && mw_rd_q == de_b_idx_q) e_b = mw_res_q;
    end
`else
    assign e_a = de_a_q;
    assign e_b = de_b_q;
`endif

    assign e_imm = {{(DATA_W-4){de_imm_q[3]}}, de_imm_q};

    always_comb begin
        e_alu = '0;
        case (de_op_q)
            OP_ADD:                 e_alu = e_a + e_b;
            OP_SUB:                 e_alu = e_a - e_b;
            OP_AND:                 e_alu = e_a & e_b;
            OP_OR:                  e_alu = e_a | e_b;
            OP_ADDI, OP_LD, OP_ST:  e_alu = e_a + e_imm;
            default:                e_alu = '0;
        endcase
    end

    assign taken     = (de_op_q == OP_BEQ) && (e_a == e_b);
    assign br_target = de_pc_q + {{(PC_W-4){de_imm_q[3]}}, de_imm_q};

    // Anything fetched behind a HALT is squashed so it never touches state.
    assign halt_in_flight = (fd_instr_q[15:12] == 4'd9) || (de_op_q == OP_HALT) ||
                            (em_op_q == OP_HALT);

    always_comb begin
        pc_d       = pc_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        de_op_d    = de_op_q;
        de_rd_d    = de_rd_q;
        de_imm_d   = de_imm_q;
        de_a_d     = de_a_q;
        de_b_d     = de_b_q;
        de_pc_d    = de_pc_q;
`ifdef PIPE_CORE_FWD_EN
        de_a_idx_d = de_a_idx_q;
        de_b_idx_d = de_b_idx_q;
`endif
        em_op_d    = em_op_q;
        em_rd_d    = em_rd_q;
        em_alu_d   = em_alu_q;
        em_st_d    = em_st_q;
        mw_we_d    = mw_we_q;
        mw_rd_d    = mw_rd_q;
        mw_res_d   = mw_res_q;
        halted_d   = halted_q;
        if (advance) begin
            // E, M and W always move forward; only F and D ever hold.
            mw_we_d  = em_we;
            mw_rd_d  = em_rd_q;
            mw_res_d = m_res;
            em_op_d  = de_op_q;
            em_rd_d  = de_rd_q;
            em_alu_d = e_alu;
            em_st_d  = e_b;
            halted_d = halted_q || (em_op_q == OP_HALT);
            if (taken) begin
                // Flush takes priority over a coincident stall.
                pc_d       = br_target;
                fd_instr_d = '0;
                de_op_d    = OP_NOP;
            end else if (stall) begin
                de_op_d = OP_NOP;
            end else begin
                pc_d       = pc_q + PC_W'(1);
                fd_instr_d = halt_in_flight ? 16'h0000 : imem_data;
                fd_pc_d    = pc_q;
                de_op_d    = d_op;
                de_rd_d    = d_rd;
                de_imm_d   = fd_instr_q[3:0];
                de_a_d     = d_a;
                de_b_d     = d_b;
                de_pc_d    = fd_pc_q;
`ifdef PIPE_CORE_FWD_EN
                de_a_idx_d = d_rs1;
                de_b_idx_d = d_b_idx;
`endif
            end
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (advance && mw_we_q) rf_d[mw_rd_q] = mw_res_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            fd_instr_q <= '0;
            fd_pc_q    <= '0;
            de_op_q    <= OP_NOP;
            de_rd_q    <= '0;
            de_imm_q   <= '0;
            de_a_q     <= '0;
            de_b_q     <= '0;
            de_pc_q    <= '0;
`ifdef PIPE_CORE_FWD_EN
            de_a_idx_q <= '0;
            de_b_idx_q <= '0;
`endif
            em_op_q    <= OP_NOP;
            em_rd_q    <= '0;
            em_alu_q   <= '0;
            em_st_q    <= '0;
            mw_we_q    <= 1'b0;
            mw_rd_q    <= '0;
            mw_res_q   <= '0;
            halted_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            de_op_q    <= de_op_d;
            de_rd_q    <= de_rd_d;
            de_imm_q   <= de_imm_d;
            de_a_q     <= de_a_d;
            de_b_q     <= de_b_d;
            de_pc_q    <= de_pc_d;
`ifdef PIPE_CORE_FWD_EN
            de_a_idx_q <= de_a_idx_d;
            de_b_idx_q <= de_b_idx_d;
`endif
            em_op_q    <= em_op_d;
            em_rd_q    <= em_rd_d;
            em_alu_q   <= em_alu_d;
            em_st_q    <= em_st_d;
            mw_we_q    <= mw_we_d;
            mw_rd_q    <= mw_rd_d;
            mw_res_q   <= mw_res_d;
            halted_q   <= halted_d;
            rf_q       <= rf_d;
        end
    end

    // Data memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (advance && em_op_q == OP_ST) dmem[em_alu_q[DMEM_AW-1:0]] <= em_st_q;
    end

endmodule

// File: tb/tb_pipe_core_p.sv
// tb/tb_pipe_core_p.sv - directed self-checking bench for pipe_core_p
module tb_pipe_core_p;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  result_w;
    logic        result_valid;
    logic        halted;
    logic [15:0] imem [256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

`ifdef PIPE_CORE_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    pipe_core_p #(.DATA_W(8), .PC_W(12), .DMEM_AW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .result_w     (result_w),
        .result_valid (result_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        enable = 1'b1;
        reset  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    // Steps until the next writeback, then checks value and the cycle it landed in.
    task automatic expect_wb(input string tag, input logic [7:0] v, input int c);
        int n = 0;
        do begin
            step();
            n++;
        end while (result_valid !== 1'b1 && n < 40);
        chk({tag, "_valid"}, 32'(result_valid), 1);
        chk({tag, "_data"}, 32'(result_w), 32'(v));
        chk({tag, "_cycle"}, 32'(cyc), 32'(c));
    endtask

    initial begin
        // Dependent ADD after two ADDIs
        clear_imem();
        imem[0] = 16'h5105;
        imem[1] = 16'h5203;
        imem[2] = 16'h1312;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_pc", 32'(imem_addr), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_result", 32'(result_w), 0);
        chk("rst_halted", 32'(halted), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        expect_wb("add_r1", 8'd5, 4);
        expect_wb("add_r2", 8'd3, 5);
        expect_wb("add_r3", 8'd8, FWD ? 6 : 8);

        // Register file clears on reset: r1+r2 reads zero afterwards
        clear_imem();
        imem[0] = 16'h1412;
        do_reset();
        expect_wb("rf_reset", 8'd0, 4);

        // Store then load, with load-use dependency
        clear_imem();
        imem[0] = 16'h5407;
        imem[1] = 16'h7402;
        imem[2] = 16'h6502;
        imem[3] = 16'h1655;
        do_reset();
        expect_wb("ld_r4", 8'd7, 4);
        expect_wb("ld_r5", 8'd7, FWD ? 6 : 8);
        expect_wb("ld_r6", 8'd14, FWD ? 8 : 11);

        // Taken branch at PC 4 skips PC 5 and 6
        clear_imem();
        imem[0] = 16'h5101;
        imem[4] = 16'h8003;
        imem[5] = 16'h5709;
        imem[6] = 16'h570A;
        imem[7] = 16'h5804;
        do_reset();
        expect_wb("beq_r1", 8'd1, 4);
        step_to(5);
        chk("beq_pc5", 32'(imem_addr), 5);
        step_to(6);
        chk("beq_pc6", 32'(imem_addr), 6);
        step_to(7);
        chk("beq_pc7", 32'(imem_addr), 7);
        expect_wb("beq_r8", 8'd4, 11);

        // 8-bit wrap with enable freezes in the middle
        clear_imem();
        imem[0] = 16'h510F;
        imem[1] = 16'h1211;
        do_reset();
        step_to(2);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_pc", 32'(imem_addr), 2);
            chk("en_valid", 32'(result_valid), 0);
        end
        enable = 1'b1;
        expect_wb("wrap_ff", 8'hFF, 7);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("en_hold_valid", 32'(result_valid), 1);
            chk("en_hold_data", 32'(result_w), 32'h0FF);
        end
        enable = 1'b1;
        expect_wb("wrap_fe", 8'hFE, FWD ? 10 : 12);

        // Reset mid-stream with three instructions in flight
        clear_imem();
        imem[0] = 16'h5101;
        imem[1] = 16'h5202;
        imem[2] = 16'h5303;
        do_reset();
        step_to(3);
        chk("mid_pc_pre", 32'(imem_addr), 3);
        #1 reset = 1'b0;
        #1;
        chk("mid_pc_async", 32'(imem_addr), 0);
        chk("mid_valid_async", 32'(result_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        chk("mid_pc_release", 32'(imem_addr), 0);
        expect_wb("mid_first", 8'd1, 4);

        // HALT at PC 2
        clear_imem();
        imem[0] = 16'h5106;
        imem[2] = 16'h9000;
        imem[3] = 16'h5901;
        do_reset();
        expect_wb("halt_r1", 8'd6, 4);
        step_to(5);
        chk("halt_pre", 32'(halted), 0);
        step_to(6);
        chk("halt_set", 32'(halted), 1);
        chk("halt_pc", 32'(imem_addr), 6);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) enable = 1'b0;
            step();
            chk("halt_pc_hold", 32'(imem_addr), 6);
            chk("halt_no_wb", 32'(result_valid), 0);
            chk("halt_sticky", 32'(halted), 1);
        end
        enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
